// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (data width, parity, stop bits) with FWFT receive FIFO.
// Optional build macro UART_RX_MAJORITY_EN selects a 2-of-3 majority vote for every bit sample.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_50M,
    input  logic                          rst_n,
    input  logic                          rs232_rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W    = $clog2(DATA_BITS);
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W    = AW + 1;

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic             ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic [1:0]           sync_q, sync_d;
    logic                 line_prev_q, line_prev_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic line_s, sample, fall;
    logic finish, fe_now, push_req, push_ok, pop, full;

    assign line_s = sync_q[1];
    assign fall   = line_prev_q & ~line_s;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] mirrors sync_q[1]; the three bits are the synced line now and the two cycles before.
    logic [2:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[1:0], sync_q[0]};
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) hist_q <= '1;
        else        hist_q <= hist_d;
    end

    assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
    assign sample = line_s;
`endif

    always_comb begin
        sync_d      = {sync_q[0], rs232_rx};
        line_prev_d = line_s;
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        pe_d        = pe_q;
        fe_d        = fe_q;
        finish      = 1'b0;
        fe_now      = fe_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    pe_d    = 1'b0;
                    fe_d    = 1'b0;
                    state_d = sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    pe_d    = (^shift_q) ^ sample ^ ODD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    fe_now = fe_q | ~sample;
                    fe_d   = fe_now;
                    if (idx_q == STOP_LAST) begin
                        finish  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_err_d  = finish & fe_now;
        parity_err_d = finish & ~fe_now & pe_q;
        push_req     = finish & ~fe_now & ~pe_q;
        full         = (level_q == LVL_FULL);
        pop          = (level_q != '0) & rx_ready;
        push_ok      = push_req & (~full | pop);
        overrun_d    = push_req & full & ~pop;
        wr_ptr_d     = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            pe_q         <= 1'b0;
            fe_q         <= 1'b0;
            sync_q       <= '1;
            line_prev_q  <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            pe_q         <= pe_d;
            fe_q         <= fe_d;
            sync_q       <= sync_d;
            line_prev_q  <= line_prev_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    // Storage is not reset; masking the head with rx_valid gives rx_data = 0 whenever the FIFO is empty.
    assign rx_valid    = (level_q != '0);
    assign rx_data     = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level  = level_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1 default, 7E1 fast, 8N2 fast) driven from a
// vector table plus hand-written overrun / break / glitch / reset sequences, checked by a scoreboard.
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic line0 = 1'b1, line1 = 1'b1, line2 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;

    logic [7:0] d0;  logic v0, fe0, pe0, ov0, busy0;  logic [2:0] lvl0;
    logic [6:0] d1;  logic v1, fe1, pe1, ov1, busy1;  logic [2:0] lvl1;
    logic [7:0] d2;  logic v2, fe2, pe2, ov2, busy2;  logic [2:0] lvl2;

    uart_rx_param u_def (
        .clk_50M(clk), .rst_n(rst_n), .rs232_rx(line0), .rx_data(d0), .rx_valid(v0),
        .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun_err(ov0),
        .fifo_level(lvl0), .busy(busy0)
    );

    uart_rx_param #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_par (
        .clk_50M(clk), .rst_n(rst_n), .rs232_rx(line1), .rx_data(d1), .rx_valid(v1),
        .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun_err(ov1),
        .fifo_level(lvl1), .busy(busy1)
    );

    uart_rx_param #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_fast (
        .clk_50M(clk), .rst_n(rst_n), .rs232_rx(line2), .rx_data(d2), .rx_valid(v2),
        .rx_ready(rdy2), .frame_err(fe2), .parity_err(pe2), .overrun_err(ov2),
        .fifo_level(lvl2), .busy(busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt[3] = '{0, 0, 0};
    int pe_cnt[3] = '{0, 0, 0};
    int ov_cnt[3] = '{0, 0, 0};
    logic [8:0] q0[$], q1[$], q2[$];

    typedef struct {
        int         w;
        logic [8:0] data;
        logic       flip_par;
        logic [1:0] stop_low;
        logic       exp_push;
        int         exp_fe;
        int         exp_pe;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic int qsize(input int w);
        case (w)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void qpush(input int w, input logic [8:0] v);
        case (w)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int level(input int w);
        case (w)
            0:       return int'(lvl0);
            1:       return int'(lvl1);
            default: return int'(lvl2);
        endcase
    endfunction

    task automatic sb_pop(input int w, input logic [8:0] got);
        logic [8:0] e;
        if (qsize(w) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected_u%0d: got word 0x%0h, required no word", w, got);
        end else begin
            case (w)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("pop_data_u%0d", w), int'(got), int'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fe0) fe_cnt[0]++;
            if (fe1) fe_cnt[1]++;
            if (fe2) fe_cnt[2]++;
            if (pe0) pe_cnt[0]++;
            if (pe1) pe_cnt[1]++;
            if (pe2) pe_cnt[2]++;
            if (ov0) ov_cnt[0]++;
            if (ov1) ov_cnt[1]++;
            if (ov2) ov_cnt[2]++;
            if (v0 && rdy0) sb_pop(0, {1'b0, d0});
            if (v1 && rdy1) sb_pop(1, {2'b00, d1});
            if (v2 && rdy2) sb_pop(2, {1'b0, d2});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int w, input logic v);
        case (w)
            0:       line0 = v;
            1:       line1 = v;
            default: line2 = v;
        endcase
    endtask

    task automatic cfg(input int w, output int nb, output int div, output int ns, output int pm);
        case (w)
            0:       begin nb = 8; div = 434; ns = 1; pm = 0; end
            1:       begin nb = 7; div = 16;  ns = 1; pm = 2; end
            default: begin nb = 8; div = 16;  ns = 2; pm = 0; end
        endcase
    endtask

    task automatic send(input int w, input logic [8:0] d, input logic flip, input logic [1:0] stop_low);
        int nb, div, ns, pm;
        logic p;
        cfg(w, nb, div, ns, pm);
        p = 1'b0;
        for (int i = 0; i < nb; i++) p ^= d[i];
        if (pm == 1) p = ~p;
        p ^= flip;
        set_line(w, 1'b0);
        tick(div);
        for (int i = 0; i < nb; i++) begin
            set_line(w, d[i]);
            tick(div);
        end
        if (pm != 0) begin
            set_line(w, p);
            tick(div);
        end
        for (int s = 0; s < ns; s++) begin
            set_line(w, ~stop_low[s]);
            tick(div);
        end
        set_line(w, 1'b1);
        tick(2 * div);
    endtask

    task automatic wait_drain(input int w, input int budget);
        int n = 0;
        while (qsize(w) != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check($sformatf("drain_u%0d", w), qsize(w), 0);
    endtask

    function automatic vec_t mk(input int w, input logic [8:0] d, input logic fl,
                                input logic [1:0] sl, input logic ep, input int efe, input int epe);
        vec_t v;
        v.w = w; v.data = d; v.flip_par = fl; v.stop_low = sl;
        v.exp_push = ep; v.exp_fe = efe; v.exp_pe = epe;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe_b, pe_b, ov_b;

        vecs.push_back(mk(0, 9'h0A5, 1'b0, 2'b00, 1'b1, 0, 0));
        vecs.push_back(mk(0, 9'h03C, 1'b0, 2'b00, 1'b1, 0, 0));
        vecs.push_back(mk(1, 9'h055, 1'b0, 2'b00, 1'b1, 0, 0));
        vecs.push_back(mk(1, 9'h055, 1'b1, 2'b00, 1'b0, 0, 1));
        vecs.push_back(mk(1, 9'h02A, 1'b0, 2'b00, 1'b1, 0, 0));
        vecs.push_back(mk(2, 9'h081, 1'b0, 2'b10, 1'b0, 1, 0));
        vecs.push_back(mk(2, 9'h081, 1'b0, 2'b00, 1'b1, 0, 0));
        vecs.push_back(mk(2, 9'h000, 1'b0, 2'b00, 1'b1, 0, 0));
        vecs.push_back(mk(2, 9'h0FF, 1'b0, 2'b01, 1'b0, 1, 0));

        // Reset state
        tick(3);
        check("rst_valid", int'({v0, v1, v2}), 0);
        check("rst_data0", int'(d0), 0);
        check("rst_level", int'({lvl0, lvl1, lvl2}), 0);
        check("rst_busy", int'({busy0, busy1, busy2}), 0);
        check("rst_err", int'({fe0, pe0, ov0, fe1, pe1, ov1, fe2, pe2, ov2}), 0);
        rst_n = 1'b1;
        tick(5);

        // Table-driven frames
        foreach (vecs[k]) begin
            fe_b = fe_cnt[vecs[k].w];
            pe_b = pe_cnt[vecs[k].w];
            if (vecs[k].exp_push) qpush(vecs[k].w, vecs[k].data);
            send(vecs[k].w, vecs[k].data, vecs[k].flip_par, vecs[k].stop_low);
            check($sformatf("vec%0d_frame_err", k), fe_cnt[vecs[k].w] - fe_b, vecs[k].exp_fe);
            check($sformatf("vec%0d_parity_err", k), pe_cnt[vecs[k].w] - pe_b, vecs[k].exp_pe);
            wait_drain(vecs[k].w, 64);
            check($sformatf("vec%0d_level", k), level(vecs[k].w), 0);
        end

        // Break: line low for 20 bit times gives exactly one framing error
        fe_b = fe_cnt[2];
        line2 = 1'b0;
        tick(20 * 16);
        line2 = 1'b1;
        tick(64);
        check("break_frame_err", fe_cnt[2] - fe_b, 1);
        check("break_level", int'(lvl2), 0);
        check("break_busy", int'(busy2), 0);

        // Overrun: six words into a four-deep FIFO with no consumer
        ov_b = ov_cnt[2];
        rdy2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) qpush(2, 9'(k));
            send(2, 9'(k), 1'b0, 2'b00);
        end
        check("ovr_level", int'(lvl2), 4);
        check("ovr_count", ov_cnt[2] - ov_b, 2);
        check("ovr_head", int'(d2), 1);
        rdy2 = 1'b1;
        wait_drain(2, 64);
        check("ovr_level_drained", int'(lvl2), 0);

        // Short low glitch on idle line: START rejects it at the half-bit sample
        fe_b = fe_cnt[0];
        line0 = 1'b0;
        tick(100);
        line0 = 1'b1;
        tick(110);
        check("glitch_busy_mid", int'(busy0), 1);
        tick(20);
        check("glitch_busy_end", int'(busy0), 0);
        check("glitch_frame_err", fe_cnt[0] - fe_b, 0);
        check("glitch_valid", int'(v0), 0);

`ifdef UART_RX_MAJORITY_EN
        // 0x00 with isolated one-cycle highs spaced three cycles apart across data bit 3
        fe_b = fe_cnt[2];
        qpush(2, 9'h000);
        line2 = 1'b0;
        tick(16 * 4);
        for (int c = 0; c < 16; c++) begin
            line2 = (c % 3 == 1);
            tick(1);
        end
        line2 = 1'b0;
        tick(16 * 4);
        line2 = 1'b1;
        tick(16 * 4);
        check("maj_frame_err", fe_cnt[2] - fe_b, 0);
        wait_drain(2, 64);
`endif

        // Reset mid-frame with two words held in the FIFO
        rdy2 = 1'b0;
        qpush(2, 9'h011);
        send(2, 9'h011, 1'b0, 2'b00);
        qpush(2, 9'h022);
        send(2, 9'h022, 1'b0, 2'b00);
        check("prerst_level", int'(lvl2), 2);
        line2 = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            line2 = 1'b1;
            tick(16);
        end
        line2 = 1'b0;
        tick(8);
        check("prerst_busy", int'(busy2), 1);
        rst_n = 1'b0;
        q2.delete();
        tick(2);
        check("midrst_valid", int'(v2), 0);
        check("midrst_level", int'(lvl2), 0);
        check("midrst_busy", int'(busy2), 0);
        check("midrst_data", int'(d2), 0);
        check("midrst_err", int'({fe2, pe2, ov2}), 0);
        line2 = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(32);
        rdy2 = 1'b1;
        qpush(2, 9'h05A);
        send(2, 9'h05A, 1'b0, 2'b00);
        wait_drain(2, 64);
        check("postrst_level", int'(lvl2), 0);

        check("final_q0", qsize(0), 0);
        check("final_q1", qsize(1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
